// File: rtl/axistream_pack_arbiter.sv
// Round-robin, packet-granular arbiter feeding one axistream_pack packer.
// Optional macro ARB_PAD_EN pads short packets with zero beats up to a full packed word.
module axistream_pack_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int NUM_PACK   = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_tvalid,
    output logic [NUM_SRC-1:0]            src_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_SRC-1:0]            src_tlast,
    output logic                          dest_tvalid,
    input  logic                          dest_tready,
    output logic [DATA_WIDTH-1:0]         dest_tdata,
    output logic                          dest_tlast,
    output logic [ID_WIDTH-1:0]           dest_tid
);

    localparam int                  CNT_W     = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(NUM_PACK - 1);
    localparam logic [ID_WIDTH-1:0] GRANT_RST = ID_WIDTH'(NUM_SRC - 1);

`ifdef ARB_PAD_EN
    typedef enum logic [1:0] {IDLE, LOCKED, PAD} state_t;
`else
    typedef enum logic {IDLE, LOCKED} state_t;
`endif

    state_t                state, state_d;
    logic [ID_WIDTH-1:0]   grant, grant_d;
    logic [ID_WIDTH-1:0]   last_grant, last_grant_d;
    logic [CNT_W-1:0]      beat_cnt, beat_cnt_d;
    logic [CNT_W-1:0]      beat_next;
    logic                  req_found;
    logic [ID_WIDTH-1:0]   req_idx;
    logic [ID_WIDTH-1:0]   cand;
    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign src_data[k] = src_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = ID_WIDTH'((int'(last_grant) + i) % NUM_SRC);
            if (!req_found && src_tvalid[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    assign beat_next = (beat_cnt == CNT_LAST) ? '0 : beat_cnt + CNT_W'(1);

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        beat_cnt_d   = beat_cnt;
        dest_tvalid  = 1'b0;
        dest_tdata   = '0;
        dest_tlast   = 1'b0;
        dest_tid     = '0;
        src_tready   = '0;
        case (state)
            IDLE: begin
                if (req_found) begin
                    grant_d = req_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                dest_tvalid       = src_tvalid[grant];
                dest_tdata        = src_data[grant];
                dest_tlast        = src_tlast[grant];
                dest_tid          = grant;
                src_tready[grant] = dest_tready;
`ifdef ARB_PAD_EN
                // A short packet's tlast is held back until the pad beats complete the word.
                if (beat_cnt != CNT_LAST) dest_tlast = 1'b0;
`endif
                if (src_tvalid[grant] && dest_tready) begin
                    beat_cnt_d = beat_next;
                    if (src_tlast[grant]) begin
`ifdef ARB_PAD_EN
                        if (beat_cnt != CNT_LAST) begin
                            state_d = PAD;
                        end else begin
                            last_grant_d = grant;
                            beat_cnt_d   = '0;
                            state_d      = IDLE;
                        end
`else
                        last_grant_d = grant;
                        beat_cnt_d   = '0;
                        state_d      = IDLE;
`endif
                    end
                end
            end
`ifdef ARB_PAD_EN
            PAD: begin
                dest_tvalid = 1'b1;
                dest_tid    = grant;
                dest_tlast  = (beat_cnt == CNT_LAST);
                if (dest_tready) begin
                    beat_cnt_d = beat_next;
                    if (beat_cnt == CNT_LAST) begin
                        last_grant_d = grant;
                        beat_cnt_d   = '0;
                        state_d      = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GRANT_RST;
            beat_cnt   <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            beat_cnt   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_axistream_pack_arbiter.sv
// Scoreboard bench for axistream_pack_arbiter; expectations follow ARB_PAD_EN when defined.
module tb_axistream_pack_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int NP = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] tid;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    src_tvalid;
    logic [NS-1:0]    src_tready;
    logic [NS*DW-1:0] src_tdata;
    logic [NS-1:0]    src_tlast;
    logic             dest_tvalid;
    logic             dest_tready;
    logic [DW-1:0]    dest_tdata;
    logic             dest_tlast;
    logic [IW-1:0]    dest_tid;

    beat_t         src_q [NS][$];
    exp_t          sb [$];
    logic [NS-1:0] drv_valid = '0;
    logic [NS-1:0] pause = '0;
    logic [NS-1:0] fire = '0;
    bit            mon_en = 1'b0;
    bit            prev_last = 1'b0;
    int            total = 0;
    int            bad = 0;

    assign src_tvalid = drv_valid & ~pause;

    axistream_pack_arbiter #(
        .DATA_WIDTH(DW), .NUM_SRC(NS), .NUM_PACK(NP), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .src_tvalid(src_tvalid), .src_tready(src_tready),
        .src_tdata(src_tdata), .src_tlast(src_tlast),
        .dest_tvalid(dest_tvalid), .dest_tready(dest_tready),
        .dest_tdata(dest_tdata), .dest_tlast(dest_tlast), .dest_tid(dest_tid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Source models: hold the head beat until it is seen accepted.
    always @(negedge clk) fire = src_tvalid & src_tready;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NS; k++) begin
            if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            drv_valid[k]         = (src_q[k].size() > 0);
            src_tdata[k*DW +: DW] = drv_valid[k] ? src_q[k][0].data : '0;
            src_tlast[k]         = drv_valid[k] ? src_q[k][0].last : 1'b0;
        end
    end

    // Output monitor: scoreboard order, ready isolation and idle gap after each packet.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            exp_t got, want;
            if (prev_last) begin
                total++;
                if (dest_tvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_gap: dest_tvalid=%b want 0 after tlast", dest_tvalid);
                end
            end
            prev_last = 1'b0;
            if (dest_tvalid === 1'b1) begin
                total++;
                if ((src_tready & ~(NS'(1) << dest_tid)) !== '0) begin
                    bad++;
                    $display("FAIL ready_leak: src_tready=%b tid=%0d", src_tready, dest_tid);
                end
            end
            if (dest_tvalid === 1'b1 && dest_tready === 1'b1) begin
                total++;
                got = '{tid: dest_tid, data: dest_tdata, last: dest_tlast};
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat: got tid=%0d data=%h last=%b, want none",
                             got.tid, got.data, got.last);
                end else begin
                    want = sb.pop_front();
                    prev_last = want.last;
                    if (got !== want) begin
                        bad++;
                        $display("FAIL beat: got tid=%0d data=%h last=%b, want tid=%0d data=%h last=%b",
                                 got.tid, got.data, got.last, want.tid, want.data, want.last);
                    end
                end
            end
        end
    end

    function automatic bit srcs_empty();
        for (int k = 0; k < NS; k++) if (src_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_pkt(input int k, input logic [DW-1:0] base, input int n, input bit to_sb);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + DW'(i);
            src_q[k].push_back('{data: d, last: (i == n - 1)});
            if (to_sb) sb.push_back('{tid: IW'(k), data: d, last: (i == n - 1)});
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            if (sb.size() == 0 && srcs_empty()) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_drain: %0d beats outstanding, want 0", name, sb.size());
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        bit seen = 1'b0;
        rst = 1'b1;
        dest_tready = 1'b1;
        #2;
        total++;
        if ({dest_tvalid, dest_tlast, dest_tdata, dest_tid, src_tready} !== '0) begin
            bad++;
            $display("FAIL reset_state: outputs=%h want 0", {dest_tvalid, dest_tlast, dest_tdata, dest_tid, src_tready});
        end
        for (int k = 0; k < NS; k++) load_pkt(k, DW'(8'he0 + 8'(k * 16)), 4, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (dest_tvalid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || dest_tid !== 2'd0 || dest_tdata !== 8'he0) begin
            bad++;
            $display("FAIL first_grant: valid=%b tid=%0d data=%h, want 1 0 e0", seen, dest_tid, dest_tdata);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({dest_tvalid, dest_tlast, dest_tdata, dest_tid, src_tready} !== '0) begin
            bad++;
            $display("FAIL async_reset: outputs=%h want 0", {dest_tvalid, dest_tlast, dest_tdata, dest_tid, src_tready});
        end
        @(posedge clk); #2;
        for (int k = 0; k < NS; k++) src_q[k].delete();
        @(posedge clk); #2;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_round_robin();
        @(posedge clk); #2;
        for (int k = 0; k < NS; k++) load_pkt(k, DW'(k * 16), 4, 1'b1);
        load_pkt(0, 8'h04, 4, 1'b1);
        wait_drain(100, "round_robin");
    endtask

    task automatic test_backpressure();
        bit done = 1'b0;
        @(posedge clk); #2;
        load_pkt(2, 8'h20, 4, 1'b1);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            dest_tready = ~dest_tready;
            @(negedge clk);
            if (dest_tvalid === 1'b1) begin
                total++;
                if (src_tready !== (dest_tready ? 4'b0100 : 4'b0000)) begin
                    bad++;
                    $display("FAIL bp_ready: src_tready=%b want %b", src_tready, dest_tready ? 4'b0100 : 4'b0000);
                end
            end
            if (sb.size() == 0 && srcs_empty()) done = 1'b1;
        end
        @(posedge clk); #1;
        dest_tready = 1'b1;
        wait_drain(20, "backpressure");
    endtask

    task automatic test_grant_hold();
        bit hit = 1'b0;
        @(posedge clk); #2;
        load_pkt(1, 8'h10, 4, 1'b1);
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk); #2;
            if (src_q[1].size() == 2) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL hold_start: src1 remaining=%0d want 2", src_q[1].size());
        end
        pause[1] = 1'b1;
        load_pkt(3, 8'h30, 4, 1'b1);
        repeat (5) begin
            @(negedge clk);
            total++;
            if (dest_tvalid !== 1'b0 || src_tready !== 4'b0010) begin
                bad++;
                $display("FAIL grant_hold: valid=%b src_tready=%b want 0 0010", dest_tvalid, src_tready);
            end
        end
        @(posedge clk); #2;
        pause[1] = 1'b0;
        wait_drain(60, "grant_hold");
    endtask

    task automatic test_short_packet();
        @(posedge clk); #2;
        src_q[0].push_back('{data: 8'haa, last: 1'b0});
        src_q[0].push_back('{data: 8'hbb, last: 1'b1});
        sb.push_back('{tid: 2'd0, data: 8'haa, last: 1'b0});
`ifdef ARB_PAD_EN
        sb.push_back('{tid: 2'd0, data: 8'hbb, last: 1'b0});
        sb.push_back('{tid: 2'd0, data: 8'h00, last: 1'b0});
        sb.push_back('{tid: 2'd0, data: 8'h00, last: 1'b1});
`else
        sb.push_back('{tid: 2'd0, data: 8'hbb, last: 1'b1});
`endif
        wait_drain(30, "short_packet");
        // A following full packet must still start a fresh packed word.
        @(posedge clk); #2;
        load_pkt(1, 8'h50, 4, 1'b1);
        wait_drain(30, "after_short");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_grant_hold();
        test_short_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
